// File: rtl/vga_frame_signature.sv
// vga_frame_signature
//
// Passive monitor on the VGA stream that feeds the DAC. For each frame it
// compresses every active pixel into a MISR signature, checks the active-area
// geometry (pixels per line, lines per frame), counts completed frames and
// grabs one pixel at a selectable (column, line) position. Results update
// together once per frame, on the VS falling edge that ends the frame.
//
// Ports:
//   CLOCK_25     pixel clock, all logic on the rising edge
//   Reset_N      asynchronous active-low reset
//   VGA_VS       vertical sync, active low
//   VGA_BLANK_N  high during active video
//   VGA_R/G/B    pixel colour, COLOR_W bits each
//   Enable       run enable in continuous mode
//   Mode         0 = continuous, 1 = single-shot
//   Arm          single-shot start pulse, also releases HOLD
//   CapX, CapY   column / line of the pixel to capture
//   Signature    signature of the last completed frame
//   CapPixel     captured pixel, packed {B,G,R}
//   FrameCount   completed frames, wraps
//   LineCount    active lines in the last frame, saturating
//   PixErr       last frame had a line whose length != H_ACTIVE
//   LineErr      last frame had a line count != V_ACTIVE
//   FrameDone    one-cycle pulse when the results update
//   Busy         high while waiting for sync or measuring a frame
//
// SIG_W must be at least 3*COLOR_W so a whole pixel fits in the MISR input.

module vga_frame_signature #(
    parameter int unsigned      COLOR_W  = 8,
    parameter int unsigned      H_ACTIVE = 640,
    parameter int unsigned      V_ACTIVE = 480,
    parameter int unsigned      SIG_W    = 32,
    parameter logic [SIG_W-1:0] POLY     = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SIG_SEED = '0
) (
    input  logic                   CLOCK_25,
    input  logic                   Reset_N,
    input  logic                   VGA_VS,
    input  logic                   VGA_BLANK_N,
    input  logic [COLOR_W-1:0]     VGA_R,
    input  logic [COLOR_W-1:0]     VGA_G,
    input  logic [COLOR_W-1:0]     VGA_B,
    input  logic                   Enable,
    input  logic                   Mode,
    input  logic                   Arm,
    input  logic [9:0]             CapX,
    input  logic [9:0]             CapY,
    output logic [SIG_W-1:0]       Signature,
    output logic [3*COLOR_W-1:0]   CapPixel,
    output logic [15:0]            FrameCount,
    output logic [9:0]             LineCount,
    output logic                   PixErr,
    output logic                   LineErr,
    output logic                   FrameDone,
    output logic                   Busy
);

    localparam int unsigned PIX_W = 3 * COLOR_W;

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StSyncWait = 2'd1;
    localparam logic [1:0] StFrame    = 2'd2;
    localparam logic [1:0] StHold     = 2'd3;

    localparam logic [9:0] CntMax  = 10'h3FF;
    localparam logic [9:0] HActive = 10'(H_ACTIVE);
    localparam logic [9:0] VActive = 10'(V_ACTIVE);

    // Registered copies of the video inputs; every decision uses these.
    logic             vs_q;
    logic             blank_q;
    logic [PIX_W-1:0] rgb_q;

    // Control
    logic [1:0] state_q, state_d;
    logic       mode_q, mode_d;

    // Frame-local accumulation state
    logic [SIG_W-1:0] acc_q, acc_d;
    logic [9:0]       pix_cnt_q, pix_cnt_d;
    logic [9:0]       line_cnt_q, line_cnt_d;
    logic             pix_err_q, pix_err_d;
    logic             cap_valid_q, cap_valid_d;
    logic [PIX_W-1:0] cap_q, cap_d;

    // Published results
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [PIX_W-1:0] cap_pixel_q, cap_pixel_d;
    logic [15:0]      frame_count_q, frame_count_d;
    logic [9:0]       line_count_q, line_count_d;
    logic             pix_err_out_q, pix_err_out_d;
    logic             line_err_q, line_err_d;
    logic             frame_done_q, frame_done_d;

    // Per-cycle datapath results, valid whether or not they are committed
    logic             vs_fall;
    logic             blank_rise;
    logic             line_end;
    logic             cap_in_range;
    logic             cap_hit;
    logic [SIG_W-1:0] acc_step;
    logic [SIG_W-1:0] acc_nxt;
    logic [9:0]       pix_inc;
    logic [9:0]       line_inc;
    logic [9:0]       pix_cnt_nxt;
    logic [9:0]       line_cnt_nxt;
    logic             pix_err_nxt;
    logic             cap_valid_nxt;
    logic [PIX_W-1:0] cap_nxt;

    // FSM decode
    logic frame_end;
    logic abort;
    logic keep;

    always_comb begin
        vs_fall    = vs_q & ~VGA_VS;
        blank_rise = ~blank_q & VGA_BLANK_N;
        // A VS fall during an active pixel closes the line just like a blank fall,
        // and that last pixel still belongs to the ending frame.
        line_end   = blank_q & (~VGA_BLANK_N | vs_fall);

        acc_step = {acc_q[SIG_W-2:0], 1'b0}
                 ^ (acc_q[SIG_W-1] ? POLY : '0)
                 ^ SIG_W'(rgb_q);
        acc_nxt  = blank_q ? acc_step : acc_q;

        pix_inc  = (pix_cnt_q == CntMax) ? CntMax : pix_cnt_q + 10'd1;
        line_inc = (line_cnt_q == CntMax) ? CntMax : line_cnt_q + 10'd1;

        if (line_end || blank_rise) begin
            pix_cnt_nxt = '0;
        end else if (blank_q) begin
            pix_cnt_nxt = pix_inc;
        end else begin
            pix_cnt_nxt = pix_cnt_q;
        end

        line_cnt_nxt = line_end ? line_inc : line_cnt_q;
        // On line_end this cycle's pixel is included, so pix_inc is the line length.
        pix_err_nxt  = pix_err_q | (line_end & (pix_inc != HActive));

        // The counters are 0-based indices of the pixel being sampled now.
        cap_in_range  = (32'(CapX) < H_ACTIVE) && (32'(CapY) < V_ACTIVE);
        cap_hit       = blank_q & cap_in_range & (pix_cnt_q == CapX) & (line_cnt_q == CapY);
        cap_valid_nxt = cap_valid_q | cap_hit;
        cap_nxt       = cap_hit ? rgb_q : cap_q;
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        frame_end = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!Mode && Enable) begin
                    state_d = StSyncWait;
                    mode_d  = 1'b0;
                end else if (Mode && Arm) begin
                    state_d = StSyncWait;
                    mode_d  = 1'b1;
                end
            end
            StSyncWait: begin
                if (!mode_q && !Enable) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (vs_fall) begin
                    state_d = StFrame;
                end
            end
            StFrame: begin
                // Dropping Enable wins over a coincident frame end: nothing is published.
                if (!mode_q && !Enable) begin
                    abort   = 1'b1;
                    state_d = StIdle;
                end else if (vs_fall) begin
                    frame_end = 1'b1;
                    mode_d    = Mode;
                    state_d   = Mode ? StHold : StFrame;
                end
            end
            StHold: begin
                if (Arm) begin
                    state_d = StSyncWait;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Accumulate only while a frame is in flight; any other path restarts from seed.
    always_comb begin
        keep = (state_q == StFrame) && !frame_end && !abort;

        if (keep) begin
            acc_d       = acc_nxt;
            pix_cnt_d   = pix_cnt_nxt;
            line_cnt_d  = line_cnt_nxt;
            pix_err_d   = pix_err_nxt;
            cap_valid_d = cap_valid_nxt;
            cap_d       = cap_nxt;
        end else begin
            acc_d       = SIG_SEED;
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            pix_err_d   = 1'b0;
            cap_valid_d = 1'b0;
            cap_d       = '0;
        end
    end

    always_comb begin
        sig_d         = sig_q;
        cap_pixel_d   = cap_pixel_q;
        frame_count_d = frame_count_q;
        line_count_d  = line_count_q;
        pix_err_out_d = pix_err_out_q;
        line_err_d    = line_err_q;
        frame_done_d  = frame_end;

        if (frame_end) begin
            sig_d         = acc_nxt;
            line_count_d  = line_cnt_nxt;
            pix_err_out_d = pix_err_nxt;
            line_err_d    = (line_cnt_nxt != VActive);
            frame_count_d = frame_count_q + 16'd1;
            if (cap_valid_nxt) begin
                cap_pixel_d = cap_nxt;
            end
        end
    end

    always_ff @(posedge CLOCK_25 or negedge Reset_N) begin
        if (!Reset_N) begin
            vs_q          <= 1'b0;
            blank_q       <= 1'b0;
            rgb_q         <= '0;
            state_q       <= StIdle;
            mode_q        <= 1'b0;
            acc_q         <= SIG_SEED;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            pix_err_q     <= 1'b0;
            cap_valid_q   <= 1'b0;
            cap_q         <= '0;
            sig_q         <= '0;
            cap_pixel_q   <= '0;
            frame_count_q <= '0;
            line_count_q  <= '0;
            pix_err_out_q <= 1'b0;
            line_err_q    <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            vs_q          <= VGA_VS;
            blank_q       <= VGA_BLANK_N;
            rgb_q         <= {VGA_B, VGA_G, VGA_R};
            state_q       <= state_d;
            mode_q        <= mode_d;
            acc_q         <= acc_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            pix_err_q     <= pix_err_d;
            cap_valid_q   <= cap_valid_d;
            cap_q         <= cap_d;
            sig_q         <= sig_d;
            cap_pixel_q   <= cap_pixel_d;
            frame_count_q <= frame_count_d;
            line_count_q  <= line_count_d;
            pix_err_out_q <= pix_err_out_d;
            line_err_q    <= line_err_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign Signature  = sig_q;
    assign CapPixel   = cap_pixel_q;
    assign FrameCount = frame_count_q;
    assign LineCount  = line_count_q;
    assign PixErr     = pix_err_out_q;
    assign LineErr    = line_err_q;
    assign FrameDone  = frame_done_q;
    assign Busy       = (state_q == StSyncWait) || (state_q == StFrame);

endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed-plus-random bench for vga_frame_signature with a small 4x3 frame.
// Frames are described as arrays of lines of pixels; expected results are
// computed from those arrays and compared after the VS fall that ends a frame.

module tb_vga_frame_signature;

    localparam int H = 4;
    localparam int V = 3;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs = 1'b1;
    logic        blank_n = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic        enable = 1'b0;
    logic        mode = 1'b0;
    logic        arm = 1'b0;
    logic [9:0]  cap_x = 10'd2;
    logic [9:0]  cap_y = 10'd1;

    logic [31:0] signature;
    logic [23:0] cap_pixel;
    logic [15:0] frame_count;
    logic [9:0]  line_count;
    logic        pix_err, line_err, frame_done, busy;

    vga_frame_signature #(
        .COLOR_W  (8),
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .SIG_W    (32),
        .POLY     (POLY),
        .SIG_SEED (32'h0)
    ) dut (
        .CLOCK_25    (clk),
        .Reset_N     (rst_n),
        .VGA_VS      (vs),
        .VGA_BLANK_N (blank_n),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .Enable      (enable),
        .Mode        (mode),
        .Arm         (arm),
        .CapX        (cap_x),
        .CapY        (cap_y),
        .Signature   (signature),
        .CapPixel    (cap_pixel),
        .FrameCount  (frame_count),
        .LineCount   (line_count),
        .PixErr      (pix_err),
        .LineErr     (line_err),
        .FrameDone   (frame_done),
        .Busy        (busy)
    );

    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    // Frame description and expected results
    logic [23:0] fpix [0:7][0:7];
    int          flen [0:7];
    int          fl;

    logic [31:0] exp_sig = '0;
    logic [23:0] exp_cap = '0;
    int          exp_fc = 0;
    int          exp_lc = 0;
    logic        exp_pe = 1'b0;
    logic        exp_le = 1'b0;
    int          exp_done = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic vsync();
        vs = 1'b0;
        tick();
        tick();
        vs = 1'b1;
        tick();
        tick();
    endtask

    // kind: 0 all zero, 1 random, 2 first pixel 1 and the rest 0
    task automatic fill(input int kind, input int nl, input int long_line);
        fl = nl;
        for (int l = 0; l < 8; l++) begin
            flen[l] = (l == long_line) ? H + 1 : H;
            for (int p = 0; p < 8; p++) begin
                case (kind)
                    1:       fpix[l][p] = 24'($urandom);
                    2:       fpix[l][p] = (l == 0 && p == 0) ? 24'h000001 : 24'h0;
                    default: fpix[l][p] = 24'h0;
                endcase
            end
        end
    endtask

    task automatic play_lines(input int from, input int upto);
        for (int l = from; l < upto; l++) begin
            for (int p = 0; p < flen[l]; p++) begin
                blank_n = 1'b1;
                {b, g, r} = fpix[l][p];
                tick();
            end
            blank_n = 1'b0;
            {b, g, r} = 24'h0;
            repeat (3) tick();
        end
    endtask

    // What the frame just played should publish
    task automatic model();
        logic [31:0] acc;
        logic        any_bad;
        acc = 32'h0;
        any_bad = 1'b0;
        for (int l = 0; l < fl; l++) begin
            if (flen[l] != H) any_bad = 1'b1;
            for (int p = 0; p < flen[l]; p++) begin
                acc = (acc << 1) ^ (acc[31] ? POLY : 32'h0) ^ {8'h00, fpix[l][p]};
            end
        end
        exp_sig = acc;
        exp_lc  = fl;
        exp_pe  = any_bad;
        exp_le  = (fl != V);
        if (int'(cap_x) < H && int'(cap_y) < V && int'(cap_y) < fl && int'(cap_x) < flen[cap_y])
            exp_cap = fpix[cap_y][cap_x];
        exp_fc = (exp_fc + 1) % 65536;
        exp_done++;
    endtask

    task automatic end_frame();
        model();
        repeat (2) tick();
        vsync();
    endtask

    task automatic check_results(input string tag);
        chk({tag, "_sig"},  signature, exp_sig);
        chk({tag, "_cap"},  32'(cap_pixel), 32'(exp_cap));
        chk({tag, "_fc"},   32'(frame_count), 32'(exp_fc));
        chk({tag, "_lc"},   32'(line_count), 32'(exp_lc));
        chk({tag, "_pe"},   32'(pix_err), 32'(exp_pe));
        chk({tag, "_le"},   32'(line_err), 32'(exp_le));
        chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check_results("rst");
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_fdone", 32'(frame_done), 32'h0);
        rst_n = 1'b1;
        tick();
        enable = 1'b1;
        tick();
        tick();
        chk("start_busy", 32'(busy), 32'h1);

        // Test 1: two all-zero frames
        vsync();
        fill(0, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t1a");
        chk("t1a_fc_const", 32'(frame_count), 32'h1);
        fill(0, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t1b");
        chk("t1b_sig_const", signature, 32'h0);
        chk("t1b_lc_const", 32'(line_count), 32'h3);
        chk("t1b_fc_const", 32'(frame_count), 32'h2);

        // Test 2: single set bit in the first pixel
        fill(2, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t2");
        chk("t2_sig_const", signature, 32'h00000800);

        // Test 3: capture at (2,1), then an out-of-range column
        fill(1, 3, -1);
        fpix[1][2] = 24'hABCDEF;
        play_lines(0, fl);
        end_frame();
        check_results("t3a");
        chk("t3a_cap_const", 32'(cap_pixel), 32'h00ABCDEF);
        cap_x = 10'd9;
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t3b");
        chk("t3b_cap_const", 32'(cap_pixel), 32'h00ABCDEF);

        // Test 4: geometry errors and recovery
        cap_x = 10'd1;
        fill(1, 3, 1);
        play_lines(0, fl);
        end_frame();
        check_results("t4a");
        chk("t4a_pe_const", 32'(pix_err), 32'h1);
        fill(1, 2, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t4b");
        chk("t4b_le_const", 32'(line_err), 32'h1);
        chk("t4b_lc_const", 32'(line_count), 32'h2);
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t4c");
        chk("t4c_clean", 32'({pix_err, line_err}), 32'h0);

        // Randomized frames in continuous mode
        for (int i = 0; i < 5; i++) begin
            cap_x = 10'($urandom_range(0, 5));
            cap_y = 10'($urandom_range(0, 3));
            fill(1, int'($urandom_range(2, 4)), int'($urandom_range(0, 5)));
            play_lines(0, fl);
            end_frame();
            check_results("rnd");
        end

        // Test 6a: Enable drops mid-frame
        cap_x = 10'd3;
        cap_y = 10'd2;
        fill(1, 3, -1);
        play_lines(0, 1);
        enable = 1'b0;
        tick();
        chk("t6_en_busy0", 32'(busy), 32'h0);
        play_lines(1, fl);
        repeat (2) tick();
        vsync();
        check_results("t6_en_hold");
        enable = 1'b1;
        tick();
        chk("t6_en_busy1", 32'(busy), 32'h1);
        vsync();
        chk("t6_en_vs_busy", 32'(busy), 32'h1);
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t6_en_rec");

        // Test 5: single-shot
        enable = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        arm_pulse();
        chk("t5_armed_busy", 32'(busy), 32'h1);
        vsync();
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t5a");
        chk("t5a_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 3; i++) begin
            fill(1, 3, -1);
            play_lines(0, fl);
            repeat (2) tick();
            vsync();
        end
        check_results("t5_frozen");
        chk("t5_frozen_busy", 32'(busy), 32'h0);
        arm_pulse();
        vsync();
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t5b");

        // Test 6b: reset mid-frame
        arm_pulse();
        vsync();
        fill(1, 3, -1);
        play_lines(0, 2);
        rst_n = 1'b0;
        #1;
        exp_sig = '0;
        exp_cap = '0;
        exp_fc  = 0;
        exp_lc  = 0;
        exp_pe  = 1'b0;
        exp_le  = 1'b0;
        check_results("t6_rst");
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_fdone", 32'(frame_done), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        mode = 1'b0;
        enable = 1'b1;
        tick();
        tick();
        vsync();
        chk("t6_rst_vs_busy", 32'(busy), 32'h1);
        fill(1, 3, -1);
        play_lines(0, fl);
        end_frame();
        check_results("t6_rst_rec");
        chk("t6_rst_fc_const", 32'(frame_count), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop so a wedged run still reports
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/vga_frame_signature.md
Name: vga_frame_signature

Overview:
- Synthesizable VGA stream monitor on the pixel clock, tapped on the same VGA_* nets that drive the DAC.
- Per frame it computes a MISR signature over all active pixels, checks the active-area geometry, counts frames and captures one selectable pixel.
- It is the on-chip, parametrised successor to bench-side frame dumping: results can be compared against golden values on LEDs, or read by a host/bench without storing the image.

Parameters:
- COLOR_W, 8, bits per colour channel
- H_ACTIVE, 640, expected active pixels per line
- V_ACTIVE, 480, expected active lines per frame
- SIG_W, 32, signature width; must be >= 3*COLOR_W
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_W bits)
- SIG_SEED, 0, signature value at frame start

Ports:
- CLOCK_25  in  1  pixel clock; all logic on rising edge
- Reset_N  in  1  asynchronous active-low reset
- VGA_VS  in  1  vertical sync, active low
- VGA_BLANK_N  in  1  high during active video
- VGA_R, VGA_G, VGA_B  in  COLOR_W each  pixel colour
- Enable  in  1  continuous-mode run enable
- Mode  in  1  0 = continuous, 1 = single-shot
- Arm  in  1  single-shot start pulse; also releases HOLD
- CapX  in  10  column of the pixel to capture
- CapY  in  10  line of the pixel to capture
- Signature  out  SIG_W  last completed frame signature
- CapPixel  out  3*COLOR_W  captured pixel, packed {B,G,R}
- FrameCount  out  16  completed frames, wraps at 65535->0
- LineCount  out  10  active lines seen in the last frame; saturates at 1023
- PixErr  out  1  last frame had at least one line with a pixel count != H_ACTIVE
- LineErr  out  1  last frame had a LineCount != V_ACTIVE
- FrameDone  out  1  one-cycle pulse when results update
- Busy  out  1  high in SYNC_WAIT and FRAME

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0; the accumulator equals SIG_SEED; state is IDLE.
- Input registering:
  - VS, BLANK_N and RGB are registered once; all decisions use the registered copies (1-cycle input latency).
  - VS falling edge = registered VS 1 while the current VS is 0.
- Pixel sampling:
  - One pixel is sampled per cycle while registered BLANK_N = 1.
  - pix = zero-extend({B,G,R}) to SIG_W.
  - acc' = (acc<<1) ^ (acc[SIG_W-1] ? POLY : 0) ^ pix.
- Counters:
  - The pixel counter counts samples in the current line; it saturates at 1023 and clears on a BLANK_N rise.
  - On a BLANK_N fall (end of line): pixel counter != H_ACTIVE sets the frame-local pix_err; the line counter increments (saturating).
  - Capture happens when pixel counter == CapX and line counter == CapY during an active sample. There is no capture if either coordinate is out of range; the CapPixel register then holds its previous value.
- States:
  - IDLE: Busy=0. Mode=0 & Enable=1 -> SYNC_WAIT. Mode=1 & Arm=1 -> SYNC_WAIT.
  - SYNC_WAIT: wait for a VS falling edge -> FRAME. Clear acc (SIG_SEED), counters, pix_err and the capture-valid flag.
  - FRAME: accumulate as above. On the next VS falling edge, in a single cycle:
    - Latch Signature=acc, LineCount, PixErr=pix_err, LineErr=(lines != V_ACTIVE).
    - Latch CapPixel only if a capture occurred this frame.
    - FrameCount++ and pulse FrameDone.
    - Mode=0: stay in FRAME with the accumulator state re-cleared.
    - Mode=1: go to HOLD.
  - HOLD: outputs frozen, Busy=0. Arm -> SYNC_WAIT.
- Boundary conditions:
  - VS falling edge coinciding with BLANK_N=1: the pixel in that cycle belongs to the old frame, and the line is closed as if BLANK_N fell.
  - Enable falling in continuous mode (any state other than HOLD) -> IDLE next cycle. The partial frame is discarded, with no FrameDone and no output change.
  - Arm while in SYNC_WAIT or FRAME is ignored.
  - Mode is sampled only in IDLE and at frame end; a change mid-frame takes effect at frame end.
  - Reset mid-frame: immediate return to the reset state; no FrameDone.
  - Results of the first frame after arming are valid; lines preceding the first VS are ignored.

Test Plan:
- Parameters: H_ACTIVE=4, V_ACTIVE=3, COLOR_W=8, SIG_W=32, SIG_SEED=0; Mode=0, Enable=1.
- Test 1: two frames of all-zero pixels -> FrameDone pulses once per VS fall after the first; Signature=0, LineCount=3, PixErr=0, LineErr=0, FrameCount=1 then 2.
- Test 2: frame whose first pixel is {B,G,R}=24'h000001 and the rest 0 -> Signature=32'h00000800.
- Test 3: CapX=2, CapY=1, pixel (2,1)=24'hABCDEF -> CapPixel=24'hABCDEF. Repeat with CapX=9 -> CapPixel is unchanged.
- Test 4: line 1 carries 5 pixels -> PixErr=1, LineErr=0. A frame with 2 lines -> LineErr=1, LineCount=2. The next clean frame clears both.
- Test 5: Mode=1, Arm pulse -> exactly one FrameDone, then HOLD with outputs frozen through 3 further frames. A second Arm -> one more frame, FrameCount +1.
- Test 6: Reset_N low mid-frame, or Enable low mid-frame -> no FrameDone. Reset also zeroes all outputs; Enable low leaves outputs unchanged. Recovery: after Reset_N/Enable returns high, the next VS yields Busy=1, and the first full frame reports correct results.
